// File: rtl/operand_issue.sv
// Operand issue stage: register file, per-register pending scoreboard and a registered
// operand hand-off to the ALU. Define OPERAND_ISSUE_WB_BYPASS_EN to forward writeback data.
module operand_issue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rs1,
   input  logic [ADDR_WIDTH-1:0] in_rs2,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic                  in_use_imm,
   input  logic [2:0]            in_aluctrl,
   input  logic                  in_wr_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] aluop1,
   output logic [DATA_WIDTH-1:0] aluop2,
   output logic [2:0]            aluctrl,
   output logic [ADDR_WIDTH-1:0] out_rd,
   output logic                  out_wr_en,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data
);
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_reg [NREG];
   logic [NREG-1:0]       pending_reg;
   logic [NREG-1:0]       pending_next;

   logic                  out_valid_reg;
   logic [DATA_WIDTH-1:0] aluop1_reg;
   logic [DATA_WIDTH-1:0] aluop2_reg;
   logic [2:0]            aluctrl_reg;
   logic [ADDR_WIDTH-1:0] out_rd_reg;
   logic                  out_wr_en_reg;

   logic                  wb_hit;
   logic                  rs1_byp;
   logic                  rs2_byp;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  hazard;
   logic                  accept;
   logic [DATA_WIDTH-1:0] rs1_val;
   logic [DATA_WIDTH-1:0] rs2_val;
   logic [DATA_WIDTH-1:0] op2_val;

   assign wb_hit = wb_en && (wb_addr != '0);

`ifdef OPERAND_ISSUE_WB_BYPASS_EN
   assign rs1_byp = wb_hit && (wb_addr == in_rs1);
   assign rs2_byp = wb_hit && (wb_addr == in_rs2);
`else
   assign rs1_byp = 1'b0;
   assign rs2_byp = 1'b0;
`endif

   // A source is blocked while its register is still owed a writeback.
   assign rs1_busy = pending_reg[in_rs1] && !rs1_byp;
   assign rs2_busy = pending_reg[in_rs2] && !rs2_byp && !in_use_imm;
   assign hazard   = in_valid && (rs1_busy || rs2_busy);
   assign in_ready = (!out_valid_reg || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   assign rs1_val = rs1_byp ? wb_data : rf_reg[in_rs1];
   assign rs2_val = rs2_byp ? wb_data : rf_reg[in_rs2];
   assign op2_val = in_use_imm ? in_imm : rs2_val;

   // Per-register scoreboard update; a new claim beats a same-cycle writeback.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_pend
         if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit = accept && in_wr_en && (in_rd == ADDR_WIDTH'(gi));
            assign clr_bit = wb_en && (wb_addr == ADDR_WIDTH'(gi));
            assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
      end else if (wb_hit) begin
         rf_reg[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   // Output stage holds everything while the ALU stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         aluop1_reg    <= '0;
         aluop2_reg    <= '0;
         aluctrl_reg   <= '0;
         out_rd_reg    <= '0;
         out_wr_en_reg <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         aluop1_reg    <= rs1_val;
         aluop2_reg    <= op2_val;
         aluctrl_reg   <= in_aluctrl;
         out_rd_reg    <= in_rd;
         out_wr_en_reg <= in_wr_en;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign aluop1    = aluop1_reg;
   assign aluop2    = aluop2_reg;
   assign aluctrl   = aluctrl_reg;
   assign out_rd    = out_rd_reg;
   assign out_wr_en = out_wr_en_reg;
endmodule
